// File: rtl/mips_dp_pkg.sv
// Shared encodings for the multi-cycle MIPS datapath: ALU, operand-B and PC-source
// select codes plus instruction field positions.
package mips_dp_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_REG    = 2'b11
  } pc_source_e;

  localparam int OPCODE_LSB = 26;
  localparam int FUNC_LSB   = 0;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;
  localparam int JADDR_W    = 26;

endpackage

// File: rtl/mips_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hard-wired to zero, synchronous clear on reset.
module mips_reg_file #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         we,
  input  logic [$clog2(REG_COUNT)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_a,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_b,
  output logic [DATA_W-1:0]            rdata_a,
  output logic [DATA_W-1:0]            rdata_b
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is visible only next cycle
  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multi_cycle_datapath_p.sv
// Parametrised multi-cycle MIPS datapath with BEQ/BNE, J and JR next-PC paths.
// Optional retired-instruction counter enabled by defining DP_RETIRE_CNT_EN.
module multi_cycle_datapath_p
  import mips_dp_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                REG_COUNT = 32,
  parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              branch_ne,
  input  logic              iord,
  input  logic              instr_write,
  input  logic              reg_write,
  input  logic              alu_src_a,
  input  logic              mem_to_reg_sel,
  input  logic              reg_dest,
  input  logic [1:0]        alu_src_b,
  input  logic [1:0]        pc_source,
  input  logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic              zero_flag,
  output logic [DATA_W-1:0] pc_out
`ifdef DP_RETIRE_CNT_EN
  ,
  output logic [31:0]       instr_count
`endif
);

  localparam int IDX_W = $clog2(REG_COUNT);

  logic [DATA_W-1:0] pc, mdr, a, b, alu_out;
  logic [31:0]       ir;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result, pc_next;
  logic [DATA_W-1:0] sign_ext_imm, jump_target, rd_a, rd_b, wr_data;
  logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx, wr_idx;
  logic              pc_en;

  assign rs_idx       = ir[RS_LSB +: IDX_W];
  assign rt_idx       = ir[RT_LSB +: IDX_W];
  assign rd_idx       = ir[RD_LSB +: IDX_W];
  assign wr_idx       = reg_dest ? rd_idx : rt_idx;
  assign wr_data      = mem_to_reg_sel ? mdr : alu_out;
  assign sign_ext_imm = {{(DATA_W-IMM_W){ir[IMM_LSB+IMM_W-1]}}, ir[IMM_LSB +: IMM_W]};
  assign jump_target  = {pc[DATA_W-1:28], ir[JADDR_W-1:0], 2'b00};

  mips_reg_file #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT)
  ) u_reg_file (
    .clock  (clock),
    .reset  (reset),
    .we     (reg_write),
    .waddr  (wr_idx),
    .wdata  (wr_data),
    .raddr_a(rs_idx),
    .raddr_b(rt_idx),
    .rdata_a(rd_a),
    .rdata_b(rd_b)
  );

  assign alu_a = alu_src_a ? a : pc;

  always_comb begin
    alu_b = b;
    case (alu_src_b)
      SRCB_B:    alu_b = b;
      SRCB_FOUR: alu_b = DATA_W'(4);
      SRCB_IMM:  alu_b = sign_ext_imm;
      default:   alu_b = sign_ext_imm << 2;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = DATA_W'($signed(alu_a) < $signed(alu_b));
      default: alu_result = '0;
    endcase
  end

  assign zero_flag = (alu_result == '0);
  assign pc_en     = pc_write | (pc_write_cond & (zero_flag ^ branch_ne));

  always_comb begin
    pc_next = alu_result;
    case (pc_source)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = jump_target;
      default:      pc_next = a;
    endcase
  end

  // MDR, A, B and ALUOut are free-running; only IR and PC are gated
  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= data_in;
      a       <= rd_a;
      b       <= rd_b;
      alu_out <= alu_result;
      if (instr_write) ir <= data_in[31:0];
      if (pc_en) pc <= pc_next;
    end
  end

  assign address  = iord ? alu_out : pc;
  assign data_out = b;
  assign opcode   = ir[OPCODE_LSB +: 6];
  assign func     = ir[FUNC_LSB +: 6];
  assign pc_out   = pc;

`ifdef DP_RETIRE_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) instr_count <= '0;
    else if (instr_write) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multi_cycle_datapath_p.sv
// Scoreboard bench for multi_cycle_datapath_p: an ISA-level model predicts PC,
// memory address/data and flags; a negedge monitor pops and compares expectations.
module tb_multi_cycle_datapath_p;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int K_PC = 0, K_ADDR = 1, K_DOUT = 2, K_OPC = 3, K_FUNC = 4, K_ZERO = 5, K_CNT = 6;

  logic clock = 1'b0;
  logic reset;
  logic pc_write, pc_write_cond, branch_ne, iord, instr_write, reg_write;
  logic alu_src_a, mem_to_reg_sel, reg_dest;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_control;
  logic [31:0] data_in, address, data_out, pc_out;
  logic [5:0]  opcode, func;
  logic        zero_flag;
`ifdef DP_RETIRE_CNT_EN
  logic [31:0] instr_count;
`endif

  multi_cycle_datapath_p #(
    .DATA_W   (32),
    .REG_COUNT(32),
    .RESET_PC (RST_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .iord          (iord),
    .instr_write   (instr_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .mem_to_reg_sel(mem_to_reg_sel),
    .reg_dest      (reg_dest),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_control   (alu_control),
    .data_in       (data_in),
    .address       (address),
    .data_out      (data_out),
    .opcode        (opcode),
    .func          (func),
    .zero_flag     (zero_flag),
    .pc_out        (pc_out)
`ifdef DP_RETIRE_CNT_EN
    ,
    .instr_count   (instr_count)
`endif
  );

  always #5 clock = ~clock;

  // Architectural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  int          q_kind [$];
  logic [31:0] q_val  [$];
  string       q_name [$];
  int checks   = 0;
  int failures = 0;

  task automatic expect_out(input int kind, input logic [31:0] val, input string name);
    q_kind.push_back(kind);
    q_val.push_back(val);
    q_name.push_back(name);
  endtask

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge
  always @(negedge clock) begin
    int          k;
    logic [31:0] expv, act;
    string       nm;
    while (q_kind.size() > 0) begin
      k    = q_kind.pop_front();
      expv = q_val.pop_front();
      nm   = q_name.pop_front();
      act  = 32'hxxxx_xxxx;
      case (k)
        K_PC:   act = pc_out;
        K_ADDR: act = address;
        K_DOUT: act = data_out;
        K_OPC:  act = {26'd0, opcode};
        K_FUNC: act = {26'd0, func};
        K_ZERO: act = {31'd0, zero_flag};
`ifdef DP_RETIRE_CNT_EN
        K_CNT:  act = instr_count;
`endif
        default: act = 32'hxxxx_xxxx;
      endcase
      checks++;
      if (act !== expv) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
    end
  end

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] isa_result(input logic [5:0] fn, input logic [31:0] x,
                                             input logic [31:0] y);
    case (fn)
      6'h20:   return x + y;
      6'h22:   return x - y;
      6'h24:   return x & y;
      6'h25:   return x | y;
      6'h2a:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Control-unit decode of the R-type function field
  function automatic logic [2:0] func_to_ctl(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b011;
    endcase
  endfunction

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
  endtask

  task automatic model_reset();
    m_pc  = RST_PC;
    m_cnt = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic clear_ctrl();
    reset = 0; pc_write = 0; pc_write_cond = 0; branch_ne = 0; iord = 0;
    instr_write = 0; reg_write = 0; alu_src_a = 0; mem_to_reg_sel = 0; reg_dest = 0;
    alu_src_b = 2'b00; pc_source = 2'b00; alu_control = 3'b000; data_in = 32'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_ctrl();
  endtask

  task automatic fetch(input logic [31:0] instr);
    alu_src_a = 0; alu_src_b = 2'b01; alu_control = 3'b010; pc_source = 2'b00;
    pc_write = 1; instr_write = 1; iord = 0; data_in = instr;
    expect_out(K_ADDR, m_pc, "fetch_address");
    tick();
    m_pc  = m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    expect_out(K_PC, m_pc, "pc_after_fetch");
    expect_out(K_OPC, {26'd0, instr[31:26]}, "opcode");
    expect_out(K_FUNC, {26'd0, instr[5:0]}, "func");
  endtask

  task automatic decode();
    alu_src_a = 0; alu_src_b = 2'b11; alu_control = 3'b010;
    tick();
  endtask

  task automatic exec_alu(input logic [2:0] ctl, input logic use_imm);
    alu_src_a = 1; alu_src_b = use_imm ? 2'b10 : 2'b00; alu_control = ctl;
    tick();
  endtask

  task automatic writeback(input logic rd_sel, input logic from_mdr);
    reg_write = 1; reg_dest = rd_sel; mem_to_reg_sel = from_mdr;
    tick();
  endtask

  task automatic do_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    fetch(enc_i(6'h08, rs, rt, imm));
    decode();
    exec_alu(3'b010, 1'b1);
    writeback(1'b0, 1'b0);
    set_reg(rt, m_rf[rs] + sext(imm));
  endtask

  task automatic do_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [5:0] fn);
    fetch(enc_r(rs, rt, rd, fn));
    decode();
    exec_alu(func_to_ctl(fn), 1'b0);
    writeback(1'b1, 1'b0);
    set_reg(rd, isa_result(fn, m_rf[rs], m_rf[rt]));
  endtask

  task automatic do_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic [31:0] value);
    fetch(enc_i(6'h23, rs, rt, imm));
    decode();
    exec_alu(3'b010, 1'b1);
    iord = 1; data_in = value;
    expect_out(K_ADDR, m_rf[rs] + sext(imm), "lw_address");
    tick();
    writeback(1'b0, 1'b1);
    set_reg(rt, value);
  endtask

  task automatic do_sw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    fetch(enc_i(6'h2b, rs, rt, imm));
    decode();
    exec_alu(3'b010, 1'b1);
    iord = 1;
    expect_out(K_ADDR, m_rf[rs] + sext(imm), "sw_address");
    expect_out(K_DOUT, m_rf[rt], "sw_data");
    tick();
  endtask

  task automatic do_branch(input logic ne, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm);
    logic taken;
    fetch(enc_i(ne ? 6'h05 : 6'h04, rs, rt, imm));
    decode();
    alu_src_a = 1; alu_src_b = 2'b00; alu_control = 3'b110;
    pc_write_cond = 1; branch_ne = ne; pc_source = 2'b01;
    expect_out(K_ZERO, {31'd0, m_rf[rs] == m_rf[rt]}, "branch_zero");
    tick();
    taken = ne ? (m_rf[rs] != m_rf[rt]) : (m_rf[rs] == m_rf[rt]);
    if (taken) m_pc = m_pc + (sext(imm) << 2);
    expect_out(K_PC, m_pc, ne ? "bne_pc" : "beq_pc");
  endtask

  task automatic do_j(input logic [25:0] target);
    fetch({6'h02, target});
    pc_write = 1; pc_source = 2'b10;
    tick();
    m_pc = {m_pc[31:28], target, 2'b00};
    expect_out(K_PC, m_pc, "j_pc");
  endtask

  task automatic do_jr(input logic [4:0] rs);
    fetch(enc_r(rs, 5'd0, 5'd0, 6'h08));
    decode();
    pc_write = 1; pc_source = 2'b11;
    tick();
    m_pc = m_rf[rs];
    expect_out(K_PC, m_pc, "jr_pc");
  endtask

  // addi rt=rs=r: A captured on the write edge must hold the old value, then the new one
  task automatic same_cycle_rw(input logic [4:0] r, input logic [15:0] imm);
    logic [31:0] old_v, new_v;
    old_v = m_rf[r];
    new_v = old_v + sext(imm);
    fetch(enc_i(6'h08, r, r, imm));
    decode();
    exec_alu(3'b010, 1'b1);
    writeback(1'b0, 1'b0);
    set_reg(r, new_v);
    alu_src_a = 1; alu_src_b = 2'b10; alu_control = 3'b010; iord = 1;
    tick();
    alu_src_a = 1; alu_src_b = 2'b10; alu_control = 3'b010; iord = 1;
    expect_out(K_ADDR, old_v + sext(imm), "same_cycle_old_a");
    tick();
    iord = 1;
    expect_out(K_ADDR, new_v + sext(imm), "next_cycle_new_a");
    tick();
  endtask

  task automatic apply_random(input int n);
    for (int i = 0; i < n; i++) begin
      int          sel;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  fn;
      logic [5:0]  fns [6];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
      sel = int'($urandom_range(0, 5));
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      fn  = fns[$urandom_range(0, 5)];
      case (sel)
        0: do_addi(rs, rt, imm);
        1: do_rtype(rs, rt, rd, fn);
        2: do_lw(rs, rt, imm, $urandom);
        3: do_sw(rs, rt, imm);
        4: do_branch($urandom_range(0, 1) == 1, rs, ($urandom_range(0, 2) == 0) ? rs : rt,
                     16'($urandom_range(0, 15)) - 16'd8);
        default: do_rtype(rs, rt, rd, 6'h2a);
      endcase
    end
  endtask

  initial begin
    clear_ctrl();
    model_reset();
    reset = 1;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear_ctrl();
    expect_out(K_PC, RST_PC, "reset_pc");
    expect_out(K_OPC, 32'd0, "reset_opcode");
    expect_out(K_ADDR, RST_PC, "reset_address");
`ifdef DP_RETIRE_CNT_EN
    expect_out(K_CNT, 32'd0, "reset_count");
`endif

    do_addi(5'd0, 5'd1, 16'd5);
    do_addi(5'd0, 5'd2, 16'd5);
    do_branch(1'b0, 5'd1, 5'd2, 16'd3);
    do_branch(1'b1, 5'd1, 5'd2, 16'd3);

    do_lw(5'd0, 5'd4, 16'd0, 32'h1000_0000);
    do_jr(5'd4);
    do_j(26'h40);
    do_lw(5'd0, 5'd5, 16'd0, 32'h0000_0200);
    do_jr(5'd5);

    do_lw(5'd0, 5'd0, 16'd0, 32'h0000_DEAD);
    do_sw(5'd0, 5'd0, 16'd0);
    do_addi(5'd0, 5'd3, 16'h0011);
    same_cycle_rw(5'd3, 16'h0022);
    do_sw(5'd0, 5'd3, 16'd0);

    apply_random(40);
    for (int r = 1; r < 8; r++) do_sw(5'd0, 5'(r), 16'd0);
`ifdef DP_RETIRE_CNT_EN
    expect_out(K_CNT, m_cnt, "retire_count");
`endif

    // Abort mid-instruction with every enable asserted
    fetch(enc_i(6'h08, 5'd0, 5'd6, 16'h0077));
    decode();
    reset = 1; pc_write = 1; reg_write = 1; instr_write = 1; data_in = 32'hFFFF_FFFF;
    alu_src_a = 1; alu_src_b = 2'b10; alu_control = 3'b010;
    tick();
    model_reset();
    expect_out(K_PC, RST_PC, "midreset_pc");
    expect_out(K_OPC, 32'd0, "midreset_opcode");
`ifdef DP_RETIRE_CNT_EN
    expect_out(K_CNT, 32'd0, "midreset_count");
`endif
    for (int r = 1; r < 8; r++) do_sw(5'd0, 5'(r), 16'd0);
    do_addi(5'd0, 5'd7, 16'hFFFE);
    do_rtype(5'd7, 5'd0, 5'd6, 6'h2a);
    do_sw(5'd0, 5'd6, 16'd0);

    @(negedge clock);
    #1;
    checks++;
    if (q_kind.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", q_kind.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
